// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone-classic arbiter: round-robin, one transaction per grant,
// with a per-transaction watchdog that completes stalled cycles with fixed data.
module wb_master_arbiter #(
   parameter int                    ADDR_WIDTH     = 16,
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 8'hFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic                  m0_ack_o,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic                  m1_ack_o,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   input  logic                  s_ack_i,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   output logic                  busy_o,
   output logic                  timeout_o
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic        last_grant, last_grant_next;
   logic [15:0] timer, timer_next;

   logic                  granted;
   logic                  req_stb;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_adr;
   logic [DATA_WIDTH-1:0] req_dat;
   logic                  do_ack;
   logic                  do_timeout;
   logic                  do_abort;
   logic                  finish;
   logic [DATA_WIDTH-1:0] ret_dat;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         timer      <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         timer      <= timer_next;
      end
   end

   always_comb begin
      granted         = (state != IDLE);
      req_stb         = (state == GRANT1) ? m1_stb_i : m0_stb_i;
      req_we          = (state == GRANT1) ? m1_we_i  : m0_we_i;
      req_adr         = (state == GRANT1) ? m1_adr_i : m0_adr_i;
      req_dat         = (state == GRANT1) ? m1_dat_i : m0_dat_i;
      // A dropped strobe is an abort and takes priority; ack beats a same-cycle timeout.
      do_abort        = granted && !req_stb;
      do_ack          = granted && req_stb && s_ack_i;
      do_timeout      = granted && req_stb && !s_ack_i && (timer == TIMER_LAST);
      finish          = do_ack || do_timeout;
      ret_dat         = do_ack ? s_dat_i : TIMEOUT_DATA;

      state_next      = state;
      last_grant_next = last_grant;
      timer_next      = '0;

      case (state)
         IDLE: begin
            if (m0_stb_i && m1_stb_i) state_next = last_grant ? GRANT0 : GRANT1;
            else if (m0_stb_i)        state_next = GRANT0;
            else if (m1_stb_i)        state_next = GRANT1;
         end
         GRANT0, GRANT1: begin
            timer_next = timer + 16'd1;
            if (finish || do_abort) state_next = IDLE;
            if (finish) last_grant_next = (state == GRANT1);
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held so a mid-transaction reset never acks.
   always_comb begin
      s_stb_o   = !reset && granted && req_stb && !do_timeout;
      s_we_o    = !reset && granted && req_we;
      s_adr_o   = (!reset && granted) ? req_adr : '0;
      s_dat_o   = (!reset && granted) ? req_dat : '0;
      busy_o    = !reset && granted;
      timeout_o = !reset && do_timeout;
      m0_ack_o  = !reset && finish && (state == GRANT0);
      m1_ack_o  = !reset && finish && (state == GRANT1);
      m0_dat_o  = m0_ack_o ? ret_dat : '0;
      m1_dat_o  = m1_ack_o ? ret_dat : '0;
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: arbitration order, pass-through, timeout,
// abort and mid-grant reset, with hand-computed expectations.
module tb_wb_master_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
   logic [15:0] m0_adr_i, m1_adr_i;
   logic [7:0]  m0_dat_i, m1_dat_i;
   logic        m0_ack_o, m1_ack_o;
   logic [7:0]  m0_dat_o, m1_dat_o;
   logic        s_stb_o, s_we_o, s_ack_i;
   logic [15:0] s_adr_o;
   logic [7:0]  s_dat_o, s_dat_i;
   logic        busy_o, timeout_o;

   int total = 0;
   int bad   = 0;

   wb_master_arbiter #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8), .TIMEOUT_DATA(8'hFF)
   ) dut (
      .clock(clock), .reset(reset),
      .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
      .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
      .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; checks follow a short settle delay.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
      m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
      s_ack_i = 0; s_dat_i = '0;
      tick(); tick();
      #2;
      chk("rst_busy", busy_o, 0);
      chk("rst_stb", s_stb_o, 0);
      reset = 1'b0;
      tick(); #2;
      chk("post_rst_busy", busy_o, 0);
      chk("post_rst_ack0", m0_ack_o, 0);

      // m0 read 0xF000, bus acks on the third granted cycle with 0xA9
      m0_stb_i = 1; m0_adr_i = 16'hF000; #2;
      chk("t1_arb_latency", s_stb_o, 0);
      tick(); #2;
      chk("t1_stb", s_stb_o, 1);
      chk("t1_adr", s_adr_o, 16'hF000);
      chk("t1_we", s_we_o, 0);
      chk("t1_busy", busy_o, 1);
      chk("t1_noack_early", m0_ack_o, 0);
      tick(); tick();
      s_ack_i = 1; s_dat_i = 8'hA9; #2;
      chk("t1_ack", m0_ack_o, 1);
      chk("t1_dat", m0_dat_o, 8'hA9);
      chk("t1_ack1_quiet", m1_ack_o, 0);
      chk("t1_no_timeout", timeout_o, 0);
      tick();
      m0_stb_i = 0; s_ack_i = 0; s_dat_i = 8'h00; #2;
      chk("t1_busy_fall", busy_o, 0);
      chk("t1_dat_zero", m0_dat_o, 0);

      // simultaneous requests from reset: m0, m1, m0, m1
      reset = 1; tick(); reset = 0;
      for (int rep = 0; rep < 2; rep++) begin
         m0_stb_i = 1; m0_adr_i = 16'h1234; m1_stb_i = 1; m1_adr_i = 16'h5678;
         tick(); #2;
         chk("t2_first_m0", s_adr_o, 16'h1234);
         s_ack_i = 1; s_dat_i = 8'h11; #1;
         chk("t2_m0_ack", m0_ack_o, 1);
         chk("t2_m1_no_ack", m1_ack_o, 0);
         chk("t2_m1_dat0", m1_dat_o, 0);
         tick();
         m0_stb_i = 0; s_ack_i = 0; #2;
         chk("t2_gap_busy", busy_o, 0);
         chk("t2_gap_stb", s_stb_o, 0);
         tick(); #2;
         chk("t2_then_m1", s_adr_o, 16'h5678);
         chk("t2_then_m1_busy", busy_o, 1);
         s_ack_i = 1; s_dat_i = 8'h22; #1;
         chk("t2_m1_ack", m1_ack_o, 1);
         chk("t2_m1_dat", m1_dat_o, 8'h22);
         chk("t2_m0_no_ack", m0_ack_o, 0);
         tick();
         m1_stb_i = 0; s_ack_i = 0; s_dat_i = 0;
      end

      // m1 write 0x0085 <= 0x5A, stray ack in IDLE first
      s_ack_i = 1; #2;
      chk("stray_ack0", m0_ack_o, 0);
      chk("stray_ack1", m1_ack_o, 0);
      s_ack_i = 0;
      m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h0085; m1_dat_i = 8'h5A;
      tick(); #2;
      chk("t3_adr", s_adr_o, 16'h0085);
      chk("t3_dat", s_dat_o, 8'h5A);
      chk("t3_we", s_we_o, 1);
      s_ack_i = 1; #1;
      chk("t3_m0_quiet", m0_ack_o, 0);
      chk("t3_m1_ack", m1_ack_o, 1);
      tick();
      m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;

      // timeout: bus never acks, completes on the 8th granted cycle
      m0_stb_i = 1; m0_adr_i = 16'h0100;
      tick(); #2;
      chk("t4_c1_stb", s_stb_o, 1);
      for (int c = 2; c <= 7; c++) tick();
      #2;
      chk("t4_c7_no_to", timeout_o, 0);
      chk("t4_c7_no_ack", m0_ack_o, 0);
      tick(); #2;
      chk("t4_to", timeout_o, 1);
      chk("t4_ack", m0_ack_o, 1);
      chk("t4_dat", m0_dat_o, 8'hFF);
      chk("t4_stb_forced", s_stb_o, 0);
      tick();
      m0_stb_i = 0; #2;
      chk("t4_idle", busy_o, 0);
      chk("t4_to_pulse", timeout_o, 0);

      // abort: last winner was m0, so the tie goes to m1, which then drops out
      m0_stb_i = 1; m0_adr_i = 16'hAAAA; m1_stb_i = 1; m1_adr_i = 16'hBBBB;
      tick(); #2;
      chk("t5_m1_first", s_adr_o, 16'hBBBB);
      tick();
      m1_stb_i = 0; #2;
      chk("t5_no_ack", m1_ack_o, 0);
      chk("t5_stb_low", s_stb_o, 0);
      tick(); #2;
      chk("t5_idle", busy_o, 0);
      tick(); #2;
      chk("t5_m0_next", s_adr_o, 16'hAAAA);
      chk("t5_m0_busy", busy_o, 1);

      // reset mid-grant of m0; afterwards the first tie still goes to m0
      reset = 1; s_ack_i = 1; #2;
      chk("t6_in_rst_ack", m0_ack_o, 0);
      chk("t6_in_rst_stb", s_stb_o, 0);
      tick();
      reset = 0; s_ack_i = 0; m1_stb_i = 1; #2;
      chk("t6_after_busy", busy_o, 0);
      chk("t6_after_stb", s_stb_o, 0);
      tick(); #2;
      chk("t6_tie_m0", s_adr_o, 16'hAAAA);
      s_ack_i = 1; #1;
      chk("t6_m0_ack", m0_ack_o, 1);
      tick();
      m0_stb_i = 0; m1_stb_i = 0; s_ack_i = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
